jbi_min_err_inject_seq: RTL and testbench

JBI_MIN_ERR_INJECT_SEQ -- requirements
Module: jbi_min_err_inject_seq

---
 rtl/jbi_min_err_inject_seq.sv | 118 +++++++++++
 tb/tb_jbi_min_err_inject_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/jbi_min_err_inject_seq.sv
// JBus error-injection sequencer: hands mout one J_AD injection request at a time
// and reports completion. Define JBI_ERR_INJECT_MULTI_EN to honour the COUNT field.
module jbi_min_err_inject_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_jbi_err_inject_output,
    input  logic [23:0] csr_jbi_err_inject_count,
    input  logic        mout_min_inject_err_done,
    output logic        min_mout_inject_err,
    output logic        min_csr_inject_seq_done,
    output logic        min_inject_busy,
    output logic [23:0] min_inject_remaining
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_GAP0,
        ST_GAP1,
        ST_FIN
    } state_e;

    state_e      state_q, state_d;
    logic        en_q, en_d;
    logic        first_q, first_d;
    logic [23:0] remaining_q, remaining_d;
    logic        req_q, req_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic [23:0] load_val;
    logic        arm;

    // The first edge after reset only samples the level, so a level held high
    // through reset is never mistaken for a fresh enable.
    assign arm = csr_jbi_err_inject_output && !en_q && !first_q;

`ifdef JBI_ERR_INJECT_MULTI_EN
    assign load_val = (csr_jbi_err_inject_count == 24'd0) ? 24'd1 : csr_jbi_err_inject_count;
`else
    logic count_unused;
    assign count_unused = ^csr_jbi_err_inject_count;
    assign load_val     = 24'd1;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        remaining_d = remaining_q;
        en_d        = csr_jbi_err_inject_output;
        first_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    remaining_d = load_val;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                // Abort outranks a done arriving in the same cycle.
                if (!csr_jbi_err_inject_output) begin
                    remaining_d = 24'd0;
                    state_d     = ST_IDLE;
                end else if (mout_min_inject_err_done) begin
                    remaining_d = remaining_q - 24'd1;
                    state_d     = (remaining_q == 24'd1) ? ST_FIN : ST_GAP0;
                end
            end
            ST_GAP0, ST_GAP1: begin
                if (!csr_jbi_err_inject_output) begin
                    remaining_d = 24'd0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = (state_q == ST_GAP0) ? ST_GAP1 : ST_REQ;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                remaining_d = 24'd0;
                state_d     = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        req_d  = (state_d == ST_REQ);
        done_d = (state_d == ST_FIN);
        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            en_q        <= 1'b0;
            first_q     <= 1'b1;
            remaining_q <= 24'd0;
            req_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            first_q     <= first_d;
            remaining_q <= remaining_d;
            req_q       <= req_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign min_mout_inject_err     = req_q;
    assign min_csr_inject_seq_done = done_q;
    assign min_inject_busy         = busy_q;
    assign min_inject_remaining    = remaining_q;

endmodule

// File: tb/tb_jbi_min_err_inject_seq.sv
// Self-checking bench for jbi_min_err_inject_seq: directed scenarios plus a
// randomized run, all compared every cycle against a counter-based reference model.
module tb_jbi_min_err_inject_seq;

`ifdef JBI_ERR_INJECT_MULTI_EN
    localparam bit MULTI = 1'b1;
`else
    localparam bit MULTI = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        o_drv;
    logic [23:0] c_drv;
    logic        d_drv;
    logic        min_mout_inject_err;
    logic        min_csr_inject_seq_done;
    logic        min_inject_busy;
    logic [23:0] min_inject_remaining;

    jbi_min_err_inject_seq dut (
        .clk                       (clk),
        .rst                       (rst),
        .csr_jbi_err_inject_output (o_drv),
        .csr_jbi_err_inject_count  (c_drv),
        .mout_min_inject_err_done  (d_drv),
        .min_mout_inject_err       (min_mout_inject_err),
        .min_csr_inject_seq_done   (min_csr_inject_seq_done),
        .min_inject_busy           (min_inject_busy),
        .min_inject_remaining      (min_inject_remaining)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // Reference model: injections outstanding, cooldown cycles before the
    // request is raised again, and a pending completion pulse.
    bit m_first, m_prev, m_fin;
    int m_left, m_cool;

    int   req_rises, done_cnt;
    logic last_req;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_first = 1'b1;
        m_prev  = 1'b0;
        m_fin   = 1'b0;
        m_left  = 0;
        m_cool  = 0;
    endtask

    function automatic int load_of(input logic [23:0] c);
        if (!MULTI) return 1;
        return (c == 24'd0) ? 1 : int'(c);
    endfunction

    task automatic model_edge(input logic o, input logic d, input logic [23:0] c);
        bit arm;
        arm = o && !m_prev && !m_first;
        if (m_fin) begin
            m_fin = 1'b0;
        end else if (m_left == 0) begin
            if (arm) m_left = load_of(c);
        end else if (!o) begin
            m_left = 0;
            m_cool = 0;
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (d) begin
            m_left--;
            if (m_left == 0) m_fin = 1'b1;
            else             m_cool = 2;
        end
        m_prev  = o;
        m_first = 1'b0;
    endtask

    task automatic compare(input string tag);
        check({tag, " req"},  32'(min_mout_inject_err),     32'(m_left > 0 && m_cool == 0));
        check({tag, " done"}, 32'(min_csr_inject_seq_done), 32'(m_fin));
        check({tag, " busy"}, 32'(min_inject_busy),         32'(m_left > 0 || m_fin));
        check({tag, " rem"},  32'(min_inject_remaining),    32'(m_left));
        if (min_mout_inject_err === 1'b1 && last_req !== 1'b1) req_rises++;
        last_req = min_mout_inject_err;
        if (min_csr_inject_seq_done === 1'b1) done_cnt++;
    endtask

    task automatic step(input logic o, input logic d, input logic [23:0] c, input string tag);
        o_drv = o;
        d_drv = d;
        c_drv = c;
        @(posedge clk);
        if (!rst) model_edge(o, d, c);
        #1;
        compare(tag);
    endtask

    // Called at posedge+1: async reset pulse released well away from any edge.
    task automatic async_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        compare(tag);
        #5;
        rst = 1'b0;
    endtask

    // Arm with count c and behave as mout: answer each request lat cycles later.
    // Optionally drop the enable together with done number drop_done_idx, or in
    // GAP1 following done number drop_gap1_idx (indices from 0, -1 = never).
    task automatic run(input logic [23:0] c, input int lat, input int drop_done_idx,
                       input int drop_gap1_idx, input string tag,
                       output int reqs, output int dones);
        int   since, n_done, gap;
        bit   dropped, finished;
        logic o, d;
        req_rises = 0;
        done_cnt  = 0;
        since     = 0;
        n_done    = 0;
        gap       = -1;
        dropped   = 1'b0;
        finished  = 1'b0;
        step(1'b0, 1'b0, c, tag);
        step(1'b0, 1'b0, c, tag);
        for (int k = 0; k < 300; k++) begin
            d = (min_mout_inject_err === 1'b1) && (since == lat);
            o = 1'b1;
            if (d && n_done == drop_done_idx) o = 1'b0;
            if (gap == 0) o = 1'b0;
            if (dropped) o = 1'b0;
            step(o, d, c, tag);
            if (gap > 0) gap--;
            if (d) begin
                if (n_done == drop_gap1_idx) gap = 1;
                n_done++;
            end
            if (!o) dropped = 1'b1;
            since = (min_mout_inject_err === 1'b1) ? since + 1 : 0;
            if (k > 0 && min_inject_busy !== 1'b1) begin
                finished = 1'b1;
                break;
            end
        end
        check({tag, " finished"}, 32'(finished), 32'd1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, c, tag);
        reqs  = req_rises;
        dones = done_cnt;
    endtask

    initial begin
        int reqs, dones;
        int o_rand;
        logic [23:0] c_rand;

        rst       = 1'b1;
        o_drv     = 1'b0;
        d_drv     = 1'b0;
        c_drv     = 24'd0;
        last_req  = 1'b0;
        req_rises = 0;
        done_cnt  = 0;
        model_reset();
        #3;
        compare("reset");
        #9;
        rst = 1'b0;

        // Three injections, done five cycles after each request.
        run(24'd3, 5, -1, -1, "cnt3", reqs, dones);
        check("cnt3 requests", 32'(reqs), MULTI ? 32'd3 : 32'd1);
        check("cnt3 seq_done", 32'(dones), 32'd1);

        // Count of zero still performs one injection.
        run(24'd0, 2, -1, -1, "cnt0", reqs, dones);
        check("cnt0 requests", 32'(reqs), 32'd1);
        check("cnt0 seq_done", 32'(dones), 32'd1);

        // Enable dropped during GAP1 after the second done.
        run(24'd4, 3, -1, 1, "gap1_abort", reqs, dones);
        check("gap1_abort requests", 32'(reqs), MULTI ? 32'd2 : 32'd1);
        check("gap1_abort seq_done", 32'(dones), MULTI ? 32'd0 : 32'd1);
        check("gap1_abort busy_end", 32'(min_inject_busy), 32'd0);
        check("gap1_abort rem_end", 32'(min_inject_remaining), 32'd0);

        // Enable dropped in the same cycle as the first done: abort wins.
        run(24'd2, 4, 0, -1, "done_abort", reqs, dones);
        check("done_abort requests", 32'(reqs), 32'd1);
        check("done_abort seq_done", 32'(dones), 32'd0);

        run(24'd5, 1, -1, -1, "cnt5", reqs, dones);
        check("cnt5 requests", 32'(reqs), MULTI ? 32'd5 : 32'd1);
        check("cnt5 seq_done", 32'(dones), 32'd1);

        // Stray done while idle, then reset in REQ with the enable held high.
        step(1'b0, 1'b1, 24'd2, "stray");
        step(1'b0, 1'b1, 24'd2, "stray");
        check("stray busy", 32'(min_inject_busy), 32'd0);
        step(1'b1, 1'b0, 24'd2, "rst_arm");
        step(1'b1, 1'b0, 24'd2, "rst_arm");
        check("rst_arm req_up", 32'(min_mout_inject_err), 32'd1);
        async_reset("rst_mid");
        check("rst_mid req_low", 32'(min_mout_inject_err), 32'd0);
        req_rises = 0;
        done_cnt  = 0;
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 24'd2, "rst_hold");
        check("rst_hold requests", 32'(req_rises), 32'd0);
        check("rst_hold seq_done", 32'(done_cnt), 32'd0);
        step(1'b0, 1'b0, 24'd2, "rst_rearm");
        step(1'b1, 1'b0, 24'd2, "rst_rearm");
        check("rst_rearm req_up", 32'(min_mout_inject_err), 32'd1);
        step(1'b0, 1'b0, 24'd2, "rst_rearm");
        step(1'b0, 1'b0, 24'd2, "rst_rearm");

        // Randomized enable/done/count traffic with occasional async resets.
        o_rand = 0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 7) == 0) o_rand = 1 - o_rand;
            c_rand = ($urandom_range(0, 7) == 0) ? 24'($urandom) : 24'($urandom_range(0, 4));
            step(o_rand[0], ($urandom_range(0, 3) == 0), c_rand, "rand");
            if ($urandom_range(0, 199) == 0) async_reset("rand_rst");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
